// File: rtl/scr1_ialu_addsub_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scr1_ialu_addsub_iter: chunk-serial add/sub with saturation, NZCV flags   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module scr1_ialu_addsub_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic [1:0]       cmd_i,
  input  logic             kill_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_o,
  output logic             pos_ovflw_o,
  output logic             neg_ovflw_o,
  output logic [3:0]       flags_o
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int NLO  = (NCH > 1) ? NCH - 1 : 1;

  localparam logic [IDXW-1:0] c_LAST     = IDXW'(NCH - 1);
  localparam logic [1:0]      c_ST_IDLE  = 2'd0;
  localparam logic [1:0]      c_ST_CALC  = 2'd1;
  localparam logic [1:0]      c_ST_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sat;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [CHUNK-1:0] r_sum_ch [NLO];
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_flags;
  logic             r_pos;
  logic             r_neg;

  logic [CHUNK-1:0] w_a_ch [NCH];
  logic [CHUNK-1:0] w_b_ch [NCH];
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;
  logic             w_last;
  logic             w_pos;
  logic             w_neg;

  // Chunk views of the latched operands; r_b already holds B' (inverted for SUB).
  generate
    for (genvar g = 0; g < NCH; g++) begin : g_chunk
      assign w_a_ch[g] = r_a[g*CHUNK +: CHUNK];
      assign w_b_ch[g] = r_b[g*CHUNK +: CHUNK];
      if (g == NCH - 1) begin : g_top
        assign w_raw[g*CHUNK +: CHUNK] = w_sum[CHUNK-1:0];
      end else begin : g_low
        assign w_raw[g*CHUNK +: CHUNK] = r_sum_ch[g];
      end
    end
  endgenerate

  assign w_sum  = {1'b0, w_a_ch[r_idx]} + {1'b0, w_b_ch[r_idx]} + {{CHUNK{1'b0}}, r_carry};
  assign w_last = (r_idx == c_LAST);
  assign w_pos  = ~r_a[WIDTH-1] & ~r_b[WIDTH-1] &  w_raw[WIDTH-1];
  assign w_neg  =  r_a[WIDTH-1] &  r_b[WIDTH-1] & ~w_raw[WIDTH-1];

  always_comb begin
    w_res = w_raw;
    if (r_sat && w_pos) begin
      w_res = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (r_sat && w_neg) begin
      w_res = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (in_valid) w_state_nxt = c_ST_CALC;
      c_ST_CALC: begin
        if (kill_i) begin
          w_state_nxt = c_ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = c_ST_DONE;
        end
      end
      c_ST_DONE: if (kill_i || out_ready) w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == c_ST_IDLE);
    out_valid = (r_state == c_ST_DONE);
  end

  // Result registers only move on the final chunk, so they stay put outside DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sat   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_pos   <= 1'b0;
      r_neg   <= 1'b0;
      for (int i = 0; i < NLO; i++) begin
        r_sum_ch[i] <= '0;
      end
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (in_valid) begin
            r_a     <= op1_i;
            r_b     <= cmd_i[0] ? ~op2_i : op2_i;
            r_sat   <= cmd_i[1];
            r_carry <= cmd_i[0];
            r_idx   <= '0;
          end
        end
        c_ST_CALC: begin
          if (!kill_i) begin
            r_carry <= w_sum[CHUNK];
            if (w_last) begin
              r_res   <= w_res;
              r_flags <= {w_res[WIDTH-1], ~|w_res, w_sum[CHUNK], w_pos | w_neg};
              r_pos   <= w_pos;
              r_neg   <= w_neg;
            end else begin
              r_sum_ch[r_idx] <= w_sum[CHUNK-1:0];
              r_idx           <= r_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign res_o       = r_res;
  assign flags_o     = r_flags;
  assign pos_ovflw_o = r_pos;
  assign neg_ovflw_o = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_scr1_ialu_addsub_iter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scr1_ialu_addsub_iter: directed scoreboard bench for the iterative ALU |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_scr1_ialu_addsub_iter;

  localparam logic [1:0] c_ADD = 2'b00, c_SUB = 2'b01, c_ADDS = 2'b10, c_SUBS = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [1:0]  cmd = '0;
  logic        kill = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        pos_ovf;
  logic        neg_ovf;
  logic [3:0]  flags;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flags;
    logic        pos;
    logic        neg;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  scr1_ialu_addsub_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op1_i      (op1),
    .op2_i      (op2),
    .cmd_i      (cmd),
    .kill_i     (kill),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res_o      (res),
    .pos_ovflw_o(pos_ovf),
    .neg_ovflw_o(neg_ovf),
    .flags_o    (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got res=%h flags=%b with no pending expectation", res, flags);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (res !== e.res || flags !== e.flags || pos_ovf !== e.pos || neg_ovf !== e.neg) begin
          n_fail++;
          $display("FAIL %s: got res=%h flags=%b pos=%b neg=%b expected res=%h flags=%b pos=%b neg=%b",
                   e.name, res, flags, pos_ovf, neg_ovf, e.res, e.flags, e.pos, e.neg);
        end
      end
    end
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    op1 = a; op2 = b; cmd = c; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Issues one op, checks latency and in_ready, optionally holds out_ready low in DONE.
  task automatic run_op(input string nm, input logic [1:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [3:0] ef,
                        input logic ep, input logic en, input int hold);
    int  n;
    bit  rdy_seen;
    exp_t e;
    wait_ready(nm);
    e.name = nm; e.res = er; e.flags = ef; e.pos = ep; e.neg = en;
    q.push_back(e);
    if (hold > 0) out_ready = 1'b0;
    issue(c, a, b);
    n = 1; rdy_seen = 1'b0;
    while (!out_valid && n < 50) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; n++;
    end
    chk({nm, "_latency"}, n, 32'd5);
    chk({nm, "_busy_in_ready"}, {31'd0, rdy_seen}, 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, "_hold_res"}, res, er);
      chk({nm, "_hold_flags"}, {28'd0, flags}, {28'd0, ef});
      chk({nm, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_post_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_res", res, 32'd0);
    chk("reset_flags", {28'd0, flags}, 32'd0);
    chk("reset_ovf", {30'd0, pos_ovf, neg_ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add_basic",    c_ADD,  32'h00000001, 32'h00000002, 32'h00000003, 4'b0000, 1'b0, 1'b0, 0);
    run_op("sub_borrow",   c_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, 1'b0, 1'b0, 0);
    run_op("add_carry",    c_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 1'b0, 1'b0, 0);
    run_op("add_pos_ovf",  c_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 1'b1, 1'b0, 0);
    run_op("adds_pos_sat", c_ADDS, 32'h7FFFFFFF, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 1'b1, 1'b0, 0);
    run_op("sub_neg_ovf",  c_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, 1'b0, 1'b1, 0);
    run_op("subs_neg_sat", c_SUBS, 32'h80000000, 32'h00000001, 32'h80000000, 4'b1011, 1'b0, 1'b1, 0);
    run_op("add_chunk_cy", c_ADD,  32'h000000FF, 32'h00000001, 32'h00000100, 4'b0000, 1'b0, 1'b0, 0);
    run_op("sub_zero",     c_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, 1'b0, 1'b0, 0);
    run_op("subs_pos_sat", c_SUBS, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 4'b0001, 1'b1, 1'b0, 0);
    run_op("backpressure", c_ADD,  32'h12345678, 32'h11111111, 32'h23456789, 4'b0000, 1'b0, 1'b0, 3);

    // Kill during the second CALC cycle.
    wait_ready("kill");
    issue(c_ADD, 32'h00000010, 32'h00000020);
    @(posedge clk); #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("kill_no_valid", {31'd0, seen}, 32'd0);
    run_op("after_kill", c_ADD, 32'h00000005, 32'h00000003, 32'h00000008, 4'b0000, 1'b0, 1'b0, 0);

    // Reset in the middle of CALC clears the previously held result.
    wait_ready("rst_calc");
    issue(c_SUB, 32'h80000000, 32'h00000001);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_calc_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_calc_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_calc_res", res, 32'd0);
    chk("rst_calc_flags", {28'd0, flags}, 32'd0);
    chk("rst_calc_ovf", {30'd0, pos_ovf, neg_ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("after_rst", c_ADDS, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 4'b1011, 1'b0, 1'b1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
